sigma_mem_responder: RTL
========================

Name: sigma_mem_responder

Overview:
- Memory-side responder for the CPU's word memory port.
- Accepts word read/write requests on the 17-bit Sigma word address (bits 15:31) and returns 32-bit data.
- Models Sigma 7 core-memory access timing with a programmable number of wait states.
- Provides the req/ack handshake that the CPU fetch and operand phases will use in place of zero-latency combinational reads.

Parameters:
- DEPTH_LOG2, 12, log2 of implemented words (4096 words default, max 17).
- WAIT_CYCLES, 2, wait states inserted between request acceptance and array access (0..15).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- req  input  1  request valid; held by the requester until ack.
- we  input  1  1=write, 0=read; qualified by req.
- wstrb  input  [0:3]  byte enables for writes; bit 0 = byte 0 = data bits 0:7.
- addr  input  [15:31]  word address.
- wdata  input  [0:31]  write data.
- rdata  output  [0:31]  read data; valid while ack=1, held afterwards.
- ack  output  1  one-cycle completion pulse.
- busy  output  1  high in every state except IDLE.
- err  output  1  completion error flag; meaningful only with ack.

Behaviour:
- Reset values: rdata=0, ack=0, busy=0, err=0, state=IDLE, wait counter=0.
- Array contents are not cleared by reset.
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - If req=1, latch addr, we, wstrb and wdata, and load the counter with WAIT_CYCLES.
  - Next state is WAIT, or ACCESS when WAIT_CYCLES=0.
  - If req=0, stay in IDLE.
- WAIT: decrement the counter; go to ACCESS in the cycle the counter is 1.
- ACCESS:
  - Range check: the latched address is out of range when any addr bit above DEPTH_LOG2 is nonzero, i.e. addr[15:31-DEPTH_LOG2] != 0.
  - In range, write: update only the bytes whose wstrb bit is set.
  - In range, read: load rdata from the array.
  - Out of range: suppress the write, load rdata=0 on reads, set the err latch.
  - Next state is RESP.
- RESP:
  - ack=1 for exactly one cycle; err is valid in this cycle.
  - Writes leave rdata unchanged.
  - Next state is IDLE.
- Latency: req sampled high at edge N gives ack high in the cycle after edge N+WAIT_CYCLES+2.
- Back-to-back: if req is still high in the IDLE cycle after RESP, a new transaction starts. Minimum issue interval is WAIT_CYCLES+3 cycles.
- Input stability: addr, we, wstrb and wdata are sampled only in IDLE. Changes while busy are ignored.
- req deasserted while busy: the transaction still completes and ack is still issued.
- wstrb=0000 on a write: legal no-op; ack with err=0.
- Read-after-write to the same address returns the new data, because the write commits in ACCESS before the later read's ACCESS.
- Reset mid-operation: the state returns to IDLE on the next edge.
  - A write whose ACCESS cycle coincides with reset is not committed; reset has priority.
  - No ack is issued for an aborted transaction.
- err clears at the next IDLE to WAIT/ACCESS transition.

Optional Feature:
- Macro: SIGMA_MEM_PARITY_EN.
- Defined:
  - Each word stores one extra odd-parity bit over bits 0:31.
  - A write recomputes parity over the merged word.
  - A read checks parity; on mismatch, err=1 with ack and rdata still returns the stored data.
  - Adds input inject_par_err (1 bit); when 1 during a write's ACCESS cycle, the stored parity bit is inverted.
- Undefined: no parity storage, no inject_par_err port; err reports only out-of-range accesses.

Decomposition:
- Shared package sigma_mem_pkg:
  - Address width constant (17) and MSB index 15.
  - Word width (32) and byte-lane count (4).
  - State enumeration: IDLE, WAIT, ACCESS, RESP.
  - Parity function: odd parity over 32 bits.
- Sub-module sigma_mem_array:
  - Synchronous single-port RAM with byte-lane write enables.
  - Optional parity column.
  - Registered read data.
  - The responder FSM instantiates it.

Test Plan:
- WAIT_CYCLES=2: write addr 0x00010, wdata 0x12345678, wstrb 1111 -> ack exactly 4 cycles after req sample with err=0. Then read 0x00010 -> rdata=0x12345678.
- Partial write: wstrb 0100, wdata 0x00AB0000 onto 0x12345678 at 0x00010 -> subsequent read returns 0x12AB5678.
- Out of range with DEPTH_LOG2=12: read addr 0x01000 -> ack with err=1 and rdata=0. A write to 0x01000 leaves word 0x00000 unchanged.
- WAIT_CYCLES=0 with req held high across two reads (0x00001, then 0x00002 after ack) -> ack pulses spaced 3 cycles apart with correct data each.
- Reset asserted during the ACCESS cycle of a write of 0xDEADBEEF to 0x00020 -> no ack, busy=0 next cycle, and a later read of 0x00020 returns its prior value.
- With SIGMA_MEM_PARITY_EN: write 0x0000FFFF with inject_par_err=1, then read -> err=1 and rdata=0x0000FFFF. Rewrite without injection -> err=0.

Source files
------------

// File: rtl/sigma_mem_pkg.sv
// -----------------------------------------------------------------------------
// sigma_mem_pkg
// Shared definitions for the Sigma word-memory responder slice:
//   - Sigma word-address geometry (17 bits, numbered 15..31, MSB first)
//   - word width and byte-lane count (byte 0 = data bits 0:7)
//   - responder state enumeration
//   - odd-parity helper used by the optional parity column
// No ports (package).
// -----------------------------------------------------------------------------
package sigma_mem_pkg;

  localparam int ADDR_W   = 17;
  localparam int ADDR_MSB = 15;
  localparam int WORD_W   = 32;
  localparam int LANES    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Parity bit that makes the total count of ones (word + bit) odd.
  function automatic logic odd_parity(input logic [0:WORD_W-1] w);
    return ~(^w);
  endfunction

endpackage

// File: rtl/sigma_mem_responder_if.sv
// -----------------------------------------------------------------------------
// sigma_mem_responder_if
// Word-memory request/response bundle between the CPU (master) and the memory
// responder (slave). Bit numbering follows Sigma convention (bit 0 = MSB).
//   req    master->slave  request valid, held until ack
//   we     master->slave  1=write, 0=read
//   wstrb  master->slave  [0:3] byte enables, bit 0 = data bits 0:7
//   addr   master->slave  [15:31] word address
//   wdata  master->slave  [0:31] write data
//   rdata  slave->master  [0:31] read data, valid with ack, held afterwards
//   ack    slave->master  one-cycle completion pulse
//   busy   slave->master  transaction in progress
//   err    slave->master  completion error, meaningful with ack
// -----------------------------------------------------------------------------
interface sigma_mem_responder_if
  import sigma_mem_pkg::*;
();

  logic                req;
  logic                we;
  logic [0:LANES-1]    wstrb;
  logic [ADDR_MSB:31]  addr;
  logic [0:WORD_W-1]   wdata;
  logic [0:WORD_W-1]   rdata;
  logic                ack;
  logic                busy;
  logic                err;

  modport master (
    output req, we, wstrb, addr, wdata,
    input  rdata, ack, busy, err
  );

  modport slave (
    input  req, we, wstrb, addr, wdata,
    output rdata, ack, busy, err
  );

endinterface

// File: rtl/sigma_mem_array.sv
// -----------------------------------------------------------------------------
// sigma_mem_array
// Synchronous single-port word RAM with byte-lane write enables and a
// registered read port. Optional odd-parity column (macro SIGMA_MEM_PARITY_EN).
// Ports:
//   clk        rising-edge clock
//   i_wr_en    write strobe (lanes selected by i_wstrb)
//   i_rd_en    read strobe, loads o_rdata on the clock edge
//   i_wstrb    [0:3] byte enables, bit 0 = data bits 0:7
//   i_addr     word index
//   i_wdata    [0:31] write data
//   o_rdata    [0:31] registered read data
//   i_inject   (parity build) invert the stored parity bit on this write
//   o_par_err  (parity build) registered word fails the odd-parity check
// Contents are never cleared.
// -----------------------------------------------------------------------------
module sigma_mem_array
  import sigma_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
)
(
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic                  i_rd_en,
  input  logic [0:LANES-1]      i_wstrb,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [0:WORD_W-1]     i_wdata,
`ifdef SIGMA_MEM_PARITY_EN
  input  logic                  i_inject,
  output logic                  o_par_err,
`endif
  output logic [0:WORD_W-1]     o_rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [0:WORD_W-1] r_mem [0:DEPTH-1];
  logic [0:WORD_W-1] r_rdata;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (i_wstrb[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    if (i_rd_en) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

`ifdef SIGMA_MEM_PARITY_EN
  logic              r_par [0:DEPTH-1];
  logic              r_rpar;
  logic [0:WORD_W-1] w_merged;

  // Parity must cover the word as it will look after the lane merge,
  // so the untouched lanes come from the current contents.
  always_comb begin
    w_merged = r_mem[i_addr];
    for (int i = 0; i < LANES; i++) begin
      if (i_wstrb[i]) w_merged[8*i +: 8] = i_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) r_par[i_addr] <= odd_parity(w_merged) ^ i_inject;
    if (i_rd_en) r_rpar        <= r_par[i_addr];
  end

  assign o_par_err = (odd_parity(r_rdata) != r_rpar);
`endif

endmodule

// File: rtl/sigma_mem_responder.sv
// -----------------------------------------------------------------------------
// sigma_mem_responder
// Memory-side responder for the CPU word port. Emulates core-memory timing:
// IDLE -> WAIT (WAIT_CYCLES) -> ACCESS -> RESP -> IDLE, with ack raised for
// one cycle on the way back to IDLE (req sampled at edge N => ack visible in
// the cycle after edge N+WAIT_CYCLES+2).
// Optional feature macro: SIGMA_MEM_PARITY_EN (per-word odd parity, adds the
// inject_par_err input, parity mismatch reported on err).
// Ports:
//   clock           rising-edge clock
//   reset           synchronous, active-high
//   inject_par_err  (parity build) invert stored parity on a write's ACCESS
//   bus             sigma_mem_responder_if.slave request/response bundle
// Parameters:
//   DEPTH_LOG2   log2 of implemented words (1..17)
//   WAIT_CYCLES  wait states between acceptance and array access (0..15)
// -----------------------------------------------------------------------------
module sigma_mem_responder
  import sigma_mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_CYCLES = 2
)
(
  input  logic                 clock,
  input  logic                 reset,
`ifdef SIGMA_MEM_PARITY_EN
  input  logic                 inject_par_err,
`endif
  sigma_mem_responder_if.slave bus
);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [ADDR_MSB:31]  r_addr;
  logic                r_we;
  logic [0:LANES-1]    r_wstrb;
  logic [0:WORD_W-1]   r_wdata;
  logic [0:WORD_W-1]   r_rdata;
  logic                r_ack;
  logic                r_busy;
  logic                r_err;

  logic [ADDR_W-1:0]     w_addr_n;
  logic                  w_oor;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic [0:WORD_W-1]     w_arr_rdata;
  logic                  w_par_err;

  // Numeric view of the latched address: any set bit at or above DEPTH_LOG2
  // marks the access as out of range.
  assign w_addr_n = r_addr;
  assign w_oor    = (w_addr_n >> DEPTH_LOG2) != '0;
  assign w_idx    = w_addr_n[DEPTH_LOG2-1:0];

  // Reset gates the write directly so an aborted write never commits.
  assign w_wr_en = (r_state == ACCESS) && r_we && !w_oor && !reset;
  assign w_rd_en = (r_state == ACCESS) && !r_we && !w_oor;

  sigma_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk       (clock),
    .i_wr_en   (w_wr_en),
    .i_rd_en   (w_rd_en),
    .i_wstrb   (r_wstrb),
    .i_addr    (w_idx),
    .i_wdata   (r_wdata),
`ifdef SIGMA_MEM_PARITY_EN
    .i_inject  (inject_par_err),
    .o_par_err (w_par_err),
`endif
    .o_rdata   (w_arr_rdata)
  );

`ifndef SIGMA_MEM_PARITY_EN
  assign w_par_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req) begin
            r_addr  <= bus.addr;
            r_we    <= bus.we;
            r_wstrb <= bus.wstrb;
            r_wdata <= bus.wdata;
            r_cnt   <= 4'(WAIT_CYCLES);
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= ACCESS;
        end
        ACCESS: begin
          if (w_oor) r_err <= 1'b1;
          r_state <= RESP;
        end
        RESP: begin
          // Array read data is registered at the ACCESS edge; publish it now.
          if (!r_we) begin
            r_rdata <= w_oor ? '0 : w_arr_rdata;
            if (!w_oor && w_par_err) r_err <= 1'b1;
          end
          r_ack   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.ack   = r_ack;
  assign bus.busy  = r_busy;
  assign bus.err   = r_err;

endmodule
